// File: rtl/imm_inst_encoder.sv
// Two-stage pipelined RISC-V I/S-type instruction encoder.
// Stage 1 captures the fields and checks the immediate range and format.
// Stage 2 packs the instruction word and flags any error.
// Valid/ready handshakes on both sides; saturating encode/error counters.
module imm_inst_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      imm,
  input  logic [1:0]       ImmSrc,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             imm_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Stage 1 state
  logic        r_s1_valid;
  logic [11:0] r_s1_imm;
  logic [1:0]  r_s1_src;
  logic [6:0]  r_s1_opcode;
  logic [2:0]  r_s1_funct3;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic        r_s1_err;

  // Stage 2 state
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;

  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_range_ok;
  logic        w_src_ok;
  logic [31:0] w_pack;

  // Ready chain: a stage may load when it is empty or its contents move on.
  always_comb begin
    w_s2_adv = ~r_s2_valid | out_ready;
    w_s1_adv = ~r_s1_valid | w_s2_adv;
    // Held low throughout reset so nothing is accepted while the pipe is being cleared.
    in_ready = w_s1_adv & rst;
    w_in_hs  = in_valid & in_ready;
    w_out_hs = r_s2_valid & out_ready;
  end

  // Range/format check: the immediate must fit a signed 12-bit field.
  always_comb begin
    w_range_ok = (imm[31:11] == '0) | (imm[31:11] == '1);
    w_src_ok   = ~ImmSrc[1];
  end

  // Stage 1: capture the input fields on each input handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_imm    <= '0;
      r_s1_src    <= '0;
      r_s1_opcode <= '0;
      r_s1_funct3 <= '0;
      r_s1_rd     <= '0;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_err    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_hs;
      end
      if (w_in_hs) begin
        r_s1_imm    <= imm[11:0];
        r_s1_src    <= ImmSrc;
        r_s1_opcode <= opcode;
        r_s1_funct3 <= funct3;
        r_s1_rd     <= rd;
        r_s1_rs1    <= rs1;
        r_s1_rs2    <= rs2;
        r_s1_err    <= ~(w_range_ok & w_src_ok);
      end
    end
  end

  // Pack the stage-1 fields into the selected instruction format.
  always_comb begin
    w_pack = '0;
    case (r_s1_src)
      2'b00:   w_pack = {r_s1_imm, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      2'b01:   w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:0],
                         r_s1_opcode};
      default: w_pack = {7'b0, r_s1_rs2, r_s1_rs1, r_s1_funct3, 5'b0, r_s1_opcode};
    endcase
  end

  // Stage 2: output register, held while the downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_pack;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  // Saturating counters of completed output handshakes and errored ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_out_hs) begin
      if (r_enc_count != '1) begin
        r_enc_count <= r_enc_count + CNT_W'(1);
      end
      if (r_s2_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign instr     = r_s2_instr;
  assign imm_err   = r_s2_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: directed vectors, backpressure,
// random flow control against a reference model, reset and saturation.
module tb_imm_inst_encoder;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      imm;
  logic [1:0]       ImmSrc;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             imm_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  imm_inst_encoder #(
    .CNT_W(CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .imm      (imm),
    .ImmSrc   (ImmSrc),
    .opcode   (opcode),
    .funct3   (funct3),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instr    (instr),
    .imm_err  (imm_err),
    .enc_count(enc_count),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  src;
  } rec_t;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_instr;
    logic        exp_err;
    int          exp_enc;
    int          exp_errc;
  } vec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  bit   mon_en = 1'b1;

  // Reference encoder
  function automatic rec_t model(input logic [31:0] i, input logic [1:0] s,
                                 input logic [6:0] op, input logic [2:0] f3,
                                 input logic [4:0] d, input logic [4:0] r1,
                                 input logic [4:0] r2);
    rec_t r;
    logic [20:0] hi;
    hi    = i[31:11];
    r.imm = i;
    r.src = s;
    r.err = !(((hi == 21'h0) || (hi == 21'h1FFFFF)) && (s == 2'd0 || s == 2'd1));
    case (s)
      2'd0:    r.instr = {i[11:0], r1, f3, d, op};
      2'd1:    r.instr = {i[11:5], r2, r1, f3, i[4:0], op};
      default: r.instr = {7'b0, r2, r1, f3, 5'b0, op};
    endcase
    return r;
  endfunction

  // Immediate extender of the decode stage
  function automatic logic [31:0] extend(input logic [31:0] x, input logic [1:0] s);
    if (s == 2'd0) return {{20{x[31]}}, x[31:20]};
    return {{20{x[31]}}, x[31:25], x[11:7]};
  endfunction

  // Record handshakes that complete at the next rising edge.
  always @(negedge clk) begin
    rec_t g;
    if (mon_en && rst) begin
      if (in_valid && in_ready) exp_q.push_back(model(imm, ImmSrc, opcode, funct3, rd, rs1, rs2));
      if (out_valid && out_ready) begin
        g       = '0;
        g.instr = instr;
        g.err   = imm_err;
        got_q.push_back(g);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    step(2);
    exp_q.delete();
    got_q.delete();
    rst = 1'b1;
    step(1);
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [31:0] i, input logic [1:0] s, input logic [6:0] op,
                      input logic [2:0] f3, input logic [4:0] d, input logic [4:0] r1,
                      input logic [4:0] r2);
    bit done;
    done     = 1'b0;
    imm      = i;
    ImmSrc   = s;
    opcode   = op;
    funct3   = f3;
    rd       = d;
    rs1      = r1;
    rs2      = r2;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    imm = '0; ImmSrc = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0;
    #3;
    checks++;
    if ({in_ready, out_valid, imm_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {in_ready, out_valid, imm_err});
    end
    checks++;
    if (instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr: got %h required 00000000", instr);
    end
    checks++;
    if (enc_count !== '0 || err_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %h/%h required 0/0", enc_count, err_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
    step(1);
  endtask

  task automatic test_directed();
    vec_t v[7];
    v[0] = '{32'h00000005, 2'd0, 7'h13, 3'd0, 5'd1,  5'd2, 5'd31, 32'h00510093, 1'b0, 1, 0};
    v[1] = '{32'hFFFFFFF8, 2'd1, 7'h23, 3'd2, 5'd31, 5'd2, 5'd5,  32'hFE512C23, 1'b0, 2, 0};
    v[2] = '{32'h00000800, 2'd0, 7'h13, 3'd0, 5'd1,  5'd2, 5'd5,  32'h80010093, 1'b1, 3, 1};
    v[3] = '{32'h00000005, 2'd2, 7'h13, 3'd0, 5'd1,  5'd2, 5'd5,  32'h00510013, 1'b1, 4, 2};
    v[4] = '{32'hFFFFF800, 2'd0, 7'h13, 3'd0, 5'd0,  5'd0, 5'd0,  32'h80000013, 1'b0, 5, 2};
    v[5] = '{32'h000007FF, 2'd1, 7'h23, 3'd0, 5'd0,  5'd1, 5'd1,  32'h7E108FA3, 1'b0, 6, 2};
    v[6] = '{32'hFFFFF7FF, 2'd1, 7'h23, 3'd0, 5'd0,  5'd1, 5'd1,  32'h7E108FA3, 1'b1, 7, 3};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      send(v[k].imm, v[k].src, v[k].op, v[k].f3, v[k].rd, v[k].rs1, v[k].rs2);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early_valid: got %b required 0", k, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || instr !== v[k].exp_instr || imm_err !== v[k].exp_err) begin
        errors++;
        $display("FAIL dir%0d_word: got v=%b %h err=%b required v=1 %h err=%b", k, out_valid,
                 instr, imm_err, v[k].exp_instr, v[k].exp_err);
      end
      if (!v[k].exp_err) begin
        checks++;
        if (extend(instr, v[k].src) !== v[k].imm) begin
          errors++;
          $display("FAIL dir%0d_roundtrip: got %h required %h", k, extend(instr, v[k].src),
                   v[k].imm);
        end
      end
      step(1);
      checks++;
      if (int'(enc_count) != v[k].exp_enc || int'(err_count) != v[k].exp_errc) begin
        errors++;
        $display("FAIL dir%0d_counts: got %0d/%0d required %0d/%0d", k, enc_count, err_count,
                 v[k].exp_enc, v[k].exp_errc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want[4];
    int n;
    want[0] = 32'h00100093;
    want[1] = 32'h00200113;
    want[2] = 32'h00300193;
    want[3] = 32'h00400213;
    do_reset();
    out_ready = 1'b0;
    send(32'd1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    send(32'd2, 2'd0, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0);
    imm = 32'd3; rd = 5'd3; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr !== want[0] || exp_q.size() != 2) begin
        errors++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b %h acc=%0d required rdy=0 v=1 %h acc=2", c,
                 in_ready, out_valid, instr, exp_q.size(), want[0]);
      end
      step(1);
    end
    out_ready = 1'b1;
    send(32'd3, 2'd0, 7'h13, 3'd0, 5'd3, 5'd0, 5'd0);
    send(32'd4, 2'd0, 7'h13, 3'd0, 5'd4, 5'd0, 5'd0);
    n = 0;
    while (got_q.size() < 4 && n < 20) begin
      step(1);
      n++;
    end
    step(2);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d words required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].instr !== want[k] || got_q[k].err !== 1'b0) begin
        errors++;
        $display("FAIL bp_word%0d: got %h err=%b required %h err=0", k, got_q[k].instr,
                 got_q[k].err, want[k]);
      end
    end
    checks++;
    if (enc_count !== 16'd4) begin
      errors++;
      $display("FAIL bp_enc_count: got %0d required 4", enc_count);
    end
  endtask

  task automatic test_random();
    bit stop;
    int n;
    stop = 1'b0;
    do_reset();
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          logic [31:0] r;
          logic [31:0] ri;
          logic [1:0]  rs;
          r  = $urandom;
          ri = ($urandom_range(0, 2) == 0) ? r : {{20{r[11]}}, r[11:0]};
          rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
          step($urandom_range(0, 2));
          send(ri, rs, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          out_ready = 1'($urandom_range(0, 1));
          step(1);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (got_q.size() != 1000 || exp_q.size() != 1000) begin
      errors++;
      $display("FAIL rnd_count: got %0d out/%0d in required 1000/1000", got_q.size(),
               exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k].instr !== exp_q[k].instr || got_q[k].err !== exp_q[k].err) begin
        errors++;
        $display("FAIL rnd_word%0d: got %h err=%b required %h err=%b", k, got_q[k].instr,
                 got_q[k].err, exp_q[k].instr, exp_q[k].err);
      end
      if (!exp_q[k].err) begin
        checks++;
        if (extend(got_q[k].instr, exp_q[k].src) !== exp_q[k].imm) begin
          errors++;
          $display("FAIL rnd_roundtrip%0d: got %h required %h", k,
                   extend(got_q[k].instr, exp_q[k].src), exp_q[k].imm);
        end
      end
    end
    checks++;
    if (enc_count !== 16'd1000) begin
      errors++;
      $display("FAIL rnd_enc_count: got %0d required 1000", enc_count);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    send(32'd7, 2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0);
    step(3);
    out_ready = 1'b0;
    send(32'd1, 2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    send(32'd2, 2'd0, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstfly_flags: got v=%b rdy=%b required 0/0", out_valid, in_ready);
    end
    checks++;
    if (enc_count !== '0 || err_count !== '0) begin
      errors++;
      $display("FAIL rstfly_counts: got %0d/%0d required 0/0", enc_count, err_count);
    end
    step(2);
    exp_q.delete();
    got_q.delete();
    rst       = 1'b1;
    out_ready = 1'b1;
    step(6);
    checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstfly_stale: got %0d words v=%b required 0 words v=0", got_q.size(),
               out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mon_en    = 1'b0;
    imm       = 32'h00000800;
    ImmSrc    = 2'd0;
    opcode    = 7'h13;
    funct3    = 3'd0;
    rd        = 5'd1;
    rs1       = 5'd0;
    rs2       = 5'd0;
    in_valid  = 1'b1;
    step(65536);
    checks++;
    if (enc_count !== 16'hFFFE || err_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: got %h/%h required FFFE/FFFE", enc_count, err_count);
    end
    step(10);
    checks++;
    if (enc_count !== 16'hFFFF || err_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h/%h required FFFF/FFFF", enc_count, err_count);
    end
    in_valid = 1'b0;
    mon_en   = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_inst_encoder.md
Name: imm_inst_encoder

Overview:
- Two-stage pipelined instruction encoder: packs a 32-bit signed immediate plus register/opcode fields into a 32-bit RISC-V I-type or S-type instruction word.
- The inverse of the pipeline's immediate-extension stage. Extending `instr` with the same `ImmSrc` must return `imm` whenever `imm_err`=0.
- Used by the test/boot loader path to generate instruction memory contents in hardware.
- Valid/ready handshake on both sides; saturating encode and error counters.

Parameters:
- CNT_W, 16, width of `enc_count` and `err_count`.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  input transaction valid
- in_ready  output  1  encoder can accept input this cycle
- imm  input  32  signed immediate to encode
- ImmSrc  input  2  00 = I-type, 01 = S-type, 10/11 = unsupported
- opcode  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- rd  input  5  destination register (I-type only)
- rs1  input  5  source register 1
- rs2  input  5  source register 2 (S-type only)
- out_valid  output  1  `instr` valid
- out_ready  input  1  downstream accepts `instr`
- instr  output  32  encoded instruction
- imm_err  output  1  sideband with `instr`: immediate out of range or unsupported `ImmSrc`
- enc_count  output  CNT_W  output handshakes completed, saturating
- err_count  output  CNT_W  output handshakes with `imm_err`=1, saturating

Behaviour:
- Reset (`rst`=0, asynchronous):
  - All stage valids cleared; `out_valid`=0, `instr`=0, `imm_err`=0, `enc_count`=0, `err_count`=0.
  - `in_ready`=0 while `rst`=0, and 1 in the first cycle after release.
  - Reset mid-transaction drops all in-flight words; none are emitted after release.
- Stage 1 (capture/check):
  - Registers all inputs on the input handshake (`in_valid` & `in_ready`).
  - Computes `range_ok` = (`imm[31:11]` all 0 or all 1).
  - Computes `src_ok` = (`ImmSrc`==00 or `ImmSrc`==01).
- Stage 2 (pack):
  - I-type: `instr` = {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type: `instr` = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Unsupported `ImmSrc`: `instr` = {7'b0, rs2, rs1, funct3, 5'b0, opcode}.
  - `imm_err` = !(`range_ok` & `src_ok`).
  - Out-of-range immediates are truncated to `imm[11:0]` and still emitted, with `imm_err`=1.
- Latency: 2 cycles from input handshake to `out_valid` when there is no backpressure. Full throughput is 1 word/cycle.
- Flow control:
  - s2 advances when !s2_valid | `out_ready`.
  - s1 advances when !s1_valid | s2 advances.
  - `in_ready` = s1 advances. This is combinational from `out_ready` (one-level ready chain, accepted).
  - While `out_valid`=1 and `out_ready`=0: `instr` and `imm_err` are held stable, and no data is lost or duplicated.
  - `out_valid` never drops without a handshake.
  - At most 2 words are in flight. When both stages are full and `out_ready`=0, `in_ready`=0.
- Counters:
  - `enc_count` increments on each output handshake.
  - `err_count` increments on output handshakes with `imm_err`=1.
  - Both stick at 2^CNT_W−1.
  - Simultaneous input and output handshakes in the same cycle are both honoured.
- `rd` is ignored for S-type; `rs2` is ignored for I-type. Unused fields never affect `instr`.

Test Plan:
- Reset, then `ImmSrc`=00, `imm`=0x00000005, `rs1`=2, `funct3`=0, `rd`=1, `opcode`=0x13, `out_ready`=1 -> two cycles later `instr`=0x00510093, `imm_err`=0, `enc_count`=1.
- `ImmSrc`=01, `imm`=0xFFFFFFF8 (−8), `rs1`=2, `rs2`=5, `funct3`=2, `opcode`=0x23 -> `instr`=0xFE512C23, `imm_err`=0; extending the result with `ImmSrc`=01 returns 0xFFFFFFF8.
- `ImmSrc`=00, `imm`=0x00000800 (out of range) -> `instr`[31:20]=0x800, `imm_err`=1, `err_count`=1. Repeat with `ImmSrc`=10 -> `imm_err`=1, immediate fields zero, `err_count`=2.
- Stream 4 words with `out_ready`=0 -> `in_ready` drops after 2 accepted, `instr` stable. Release `out_ready` -> all 4 words emerge in order, no duplicates, `enc_count`=4.
- Random `in_valid`/`out_ready` with 1000 random I/S words -> output sequence equals the reference model. Every `imm_err`=0 word round-trips through the immediate extender to its original `imm`.
- Assert `rst`=0 with 2 words in flight -> `out_valid`=0 immediately, counters 0, and no stale word after release. Force 2^16+3 handshakes with CNT_W=16 -> `enc_count`=0xFFFF.
